// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment to ASCII stream path:
//   - segment patterns {g,f,e,d,c,b,a} for the glyphs the decoder recognises
//   - the ASCII codes those glyphs map to
//   - the emitter state encoding
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Segment patterns, active-high, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // ASCII codes; b and d are lower case because that is how they render
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_1     = 8'h31;
    localparam logic [7:0] ASCII_2     = 8'h32;
    localparam logic [7:0] ASCII_3     = 8'h33;
    localparam logic [7:0] ASCII_4     = 8'h34;
    localparam logic [7:0] ASCII_5     = 8'h35;
    localparam logic [7:0] ASCII_6     = 8'h36;
    localparam logic [7:0] ASCII_7     = 8'h37;
    localparam logic [7:0] ASCII_8     = 8'h38;
    localparam logic [7:0] ASCII_9     = 8'h39;
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_B_LC  = 8'h62;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_D_LC  = 8'h64;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_F     = 8'h46;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    // Emitter states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CHAR = 2'd1,
        EOL  = 2'd2
    } emit_state_e;

endpackage

// File: rtl/seg7_char_decode.sv
// -----------------------------------------------------------------------------
// seg7_char_decode
// Combinational 7-segment pattern to ASCII lookup.
// Ports:
//   pattern_i  7  active-high segment pattern {g,f,e,d,c,b,a}
//   ascii_o    8  ASCII code, UNKNOWN_CHAR for unrecognised patterns
// -----------------------------------------------------------------------------
module seg7_char_decode #(
    parameter logic [7:0] UNKNOWN_CHAR = 8'h3F
) (
    input  logic [6:0] pattern_i,
    output logic [7:0] ascii_o
);
    import seg7_pkg::*;

    always_comb begin
        case (pattern_i)
            SEG_0:     ascii_o = ASCII_0;
            SEG_1:     ascii_o = ASCII_1;
            SEG_2:     ascii_o = ASCII_2;
            SEG_3:     ascii_o = ASCII_3;
            SEG_4:     ascii_o = ASCII_4;
            SEG_5:     ascii_o = ASCII_5;
            SEG_6:     ascii_o = ASCII_6;
            SEG_7:     ascii_o = ASCII_7;
            SEG_8:     ascii_o = ASCII_8;
            SEG_9:     ascii_o = ASCII_9;
            SEG_A:     ascii_o = ASCII_A;
            SEG_B:     ascii_o = ASCII_B_LC;
            SEG_C:     ascii_o = ASCII_C;
            SEG_D:     ascii_o = ASCII_D_LC;
            SEG_E:     ascii_o = ASCII_E;
            SEG_F:     ascii_o = ASCII_F;
            SEG_DASH:  ascii_o = ASCII_DASH;
            SEG_BLANK: ascii_o = ASCII_SPACE;
            default:   ascii_o = UNKNOWN_CHAR;
        endcase
    end

endmodule

// File: rtl/segment7_ascii_stream.sv
// -----------------------------------------------------------------------------
// segment7_ascii_stream
// Samples a time-multiplexed N-digit 7-segment bus, assembles whole frames,
// debounces them over STABLE_SCANS identical scans and streams each newly
// stable frame as ASCII (leftmost digit first) followed by EOL_CHAR.
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   sample_stb    seg/dig_en valid this cycle
//   dig_en        one-hot digit select, MSB = leftmost digit
//   seg           segment pattern {g,f,e,d,c,b,a}
//   out_valid/out_ready/out_data/out_last   byte stream, out_last on EOL
//   overrun       one-cycle pulse when an unsent pending frame is replaced
// -----------------------------------------------------------------------------
module segment7_ascii_stream #(
    parameter int         N_DIGITS       = 4,
    parameter int         STABLE_SCANS   = 2,
    parameter bit         ACTIVE_LOW_SEG = 1'b0,
    parameter logic [7:0] EOL_CHAR       = 8'h0A,
    parameter logic [7:0] UNKNOWN_CHAR   = 8'h3F
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_stb,
    input  logic [N_DIGITS-1:0] dig_en,
    input  logic [6:0]          seg,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_data,
    output logic                out_last,
    output logic                overrun
);
    import seg7_pkg::*;

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_SCANS);
    localparam logic [IDX_W-1:0] IDX_LEFT = IDX_W'(N_DIGITS - 1);

    typedef logic [N_DIGITS-1:0][7:0] frame_t;

    // ---------------------------------------------------------------- capture
    logic [6:0]          seg_pol;
    logic [7:0]          dec_char;
    logic                dig_onehot;
    logic                capture_we;
    logic                commit;
    frame_t              cap_q, cap_d;
    logic [N_DIGITS-1:0] mask_q, mask_d;

    assign seg_pol = ACTIVE_LOW_SEG ? ~seg : seg;

    seg7_char_decode #(
        .UNKNOWN_CHAR(UNKNOWN_CHAR)
    ) u_decode (
        .pattern_i(seg_pol),
        .ascii_o  (dec_char)
    );

    // x & (x-1) clears the lowest set bit; zero result with x!=0 means one-hot
    assign dig_onehot = (dig_en != '0) &&
                        ((dig_en & (dig_en - N_DIGITS'(1))) == '0);
    assign capture_we = sample_stb && dig_onehot;
    assign commit     = &mask_q;

    // A strobe landing on the commit edge starts the next frame's mask.
    always_comb begin
        cap_d  = cap_q;
        mask_d = commit ? '0 : mask_q;
        if (capture_we) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (dig_en[i]) cap_d[i] = dec_char;
            end
            mask_d = mask_d | dig_en;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q  <= '0;
            mask_q <= '0;
        end else begin
            cap_q  <= cap_d;
            mask_q <= mask_d;
        end
    end

    // -------------------------------------------------------------- debounce
    frame_t           prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qualify;

    frame_t           pend_q, pend_d;
    logic             pvld_q, pvld_d;
    frame_t           lastq_q, lastq_d;
    logic             qvld_q, qvld_d;
    logic             overrun_q, overrun_d;
    logic             take;

    emit_state_e      state_q, state_d;
    frame_t           shreg_q, shreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        prev_d = prev_q;
        cnt_d  = cnt_q;
        if (commit) begin
            if (cap_q == prev_q) begin
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end else begin
                prev_d = cap_q;
                cnt_d  = CNT_W'(1);
            end
        end
    end

    // Saturation keeps cnt at max on later identical commits; last_queued
    // stops those from re-emitting the same frame.
    assign qualify = commit && (cnt_d == CNT_MAX) &&
                     (!qvld_q || (cap_q != lastq_q));

    // ---------------------------------------------------------- pending slot
    assign take = (state_q == IDLE) && pvld_q;

    // New frame wins over the emitter's take in the same cycle, so a frame
    // arriving just as the emitter grabs the old one is kept, not counted
    // as an overrun.
    always_comb begin
        pend_d    = pend_q;
        pvld_d    = pvld_q;
        lastq_d   = lastq_q;
        qvld_d    = qvld_q;
        overrun_d = 1'b0;
        if (take) pvld_d = 1'b0;
        if (qualify) begin
            pend_d    = cap_q;
            pvld_d    = 1'b1;
            lastq_d   = cap_q;
            qvld_d    = 1'b1;
            overrun_d = pvld_q && !take;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            cnt_q     <= '0;
            pend_q    <= '0;
            pvld_q    <= 1'b0;
            lastq_q   <= '0;
            qvld_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            pvld_q    <= pvld_d;
            lastq_q   <= lastq_d;
            qvld_q    <= qvld_d;
            overrun_q <= overrun_d;
        end
    end

    // --------------------------------------------------------------- emitter
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pvld_q) begin
                    shreg_d = pend_q;
                    idx_d   = IDX_LEFT;
                    state_d = CHAR;
                end
            end
            CHAR: begin
                if (out_ready) begin
                    if (idx_q == '0) state_d = EOL;
                    else             idx_d   = idx_q - IDX_W'(1);
                end
            end
            EOL: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs decode straight from registers, so reset forces them at once.
    always_comb begin
        out_data = 8'h00;
        out_last = 1'b0;
        case (state_q)
            CHAR:    out_data = shreg_q[idx_q];
            EOL: begin
                out_data = EOL_CHAR;
                out_last = 1'b1;
            end
            default: out_data = 8'h00;
        endcase
    end

    assign out_valid = (state_q != IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_segment7_ascii_stream.sv
module tb_segment7_ascii_stream;
    localparam int N = 4;
    localparam int S = 2;
    localparam logic [7:0] EOL = 8'h0A;

    typedef logic [N-1:0][6:0] pats_t;
    typedef logic [N-1:0][7:0] frame_t;

    logic         clk;
    logic         rst_n;
    logic         sample_stb;
    logic [N-1:0] dig_en;
    logic [6:0]   seg;
    logic         out_ready = 1'b0;
    logic         out_valid, out_last, overrun;
    logic [7:0]   out_data;
    logic         out_valid1, out_last1, overrun1;
    logic [7:0]   out_data1;

    logic ready_cmd;
    logic rand_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int ovr_cnt  = 0;

    logic [8:0] obs[$];
    logic [8:0] obs1[$];
    logic [8:0] exp_q[$];
    frame_t     hist[$];
    frame_t     last_q;
    bit         have_last;

    segment7_ascii_stream dut (
        .clk(clk), .rst_n(rst_n), .sample_stb(sample_stb), .dig_en(dig_en),
        .seg(seg), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .overrun(overrun)
    );

    // Second instance: single-scan debounce, common-anode bus fed inverted.
    segment7_ascii_stream #(.STABLE_SCANS(1), .ACTIVE_LOW_SEG(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_stb(sample_stb), .dig_en(dig_en),
        .seg(~seg), .out_valid(out_valid1), .out_ready(1'b1),
        .out_data(out_data1), .out_last(out_last1), .overrun(overrun1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
        end
    end

    // Transfers happen at the next rising edge; inputs are stable across it.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) obs.push_back({out_last, out_data});
        if (rst_n && out_valid1) obs1.push_back({out_last1, out_data1});
        if (rst_n && overrun) ovr_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------- reference model
    function automatic logic [7:0] ref_decode(input logic [6:0] p);
        case (p)
            7'h3F: return 8'h30;  7'h06: return 8'h31;  7'h5B: return 8'h32;
            7'h4F: return 8'h33;  7'h66: return 8'h34;  7'h6D: return 8'h35;
            7'h7D: return 8'h36;  7'h07: return 8'h37;  7'h7F: return 8'h38;
            7'h6F: return 8'h39;  7'h77: return "A";    7'h7C: return "b";
            7'h39: return "C";    7'h5E: return "d";    7'h79: return "E";
            7'h71: return "F";    7'h40: return "-";    7'h00: return " ";
            default: return 8'h3F;
        endcase
    endfunction

    // A frame is sent when the last S commits are identical and it is not
    // the frame most recently sent.
    task automatic model_commit(input frame_t f);
        bit same;
        hist.push_back(f);
        if (hist.size() > S) void'(hist.pop_front());
        if (hist.size() == S) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != f) same = 1'b0;
            if (same && (!have_last || f != last_q)) begin
                last_q    = f;
                have_last = 1'b1;
                for (int d = N - 1; d >= 0; d--) exp_q.push_back({1'b0, f[d]});
                exp_q.push_back({1'b1, EOL});
            end
        end
    endtask

    task automatic model_reset();
        hist.delete();
        exp_q.delete();
        obs.delete();
        obs1.delete();
        have_last = 1'b0;
    endtask

    // -------------------------------------------------------------- drivers
    task automatic drive_idle();
        @(posedge clk); #1;
        sample_stb = 1'b0;
        dig_en     = '0;
        seg        = '0;
    endtask

    task automatic strobe(input int d, input logic [6:0] p);
        @(posedge clk); #1;
        sample_stb = 1'b1;
        dig_en     = '0;
        dig_en[d]  = 1'b1;
        seg        = p;
    endtask

    task automatic junk();
        logic [N-1:0] bad[5];
        bad = '{4'b0000, 4'b0011, 4'b1100, 4'b1111, 4'b0101};
        @(posedge clk); #1;
        sample_stb = 1'($urandom_range(0, 1));
        dig_en     = bad[$urandom_range(0, 4)];
        seg        = 7'($urandom);
    endtask

    task automatic scan(input pats_t p, input bit noise);
        frame_t f;
        int start, d;
        start = noise ? $urandom_range(0, N - 1) : N - 1;
        for (int j = 0; j < N; j++) begin
            d = (start - j + N) % N;
            if (noise && $urandom_range(0, 3) == 0) junk();
            if (noise && j < N - 1 && $urandom_range(0, 3) == 0) strobe(d, 7'($urandom));
            strobe(d, p[d]);
            f[d] = ref_decode(p[d]);
        end
        model_commit(f);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk); #1;
        ready_cmd = v;
    endtask

    task automatic drain(input string name);
        int idle, budget;
        idle = 0;
        budget = 0;
        while (idle < 8 && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (out_valid || out_valid1) idle = 0;
            else idle++;
        end
        n_checks++;
        if (idle < 8) begin
            n_fail++;
            $display("FAIL %s drain: stream still busy after %0d cycles, expected idle", name, budget);
        end
    endtask

    task automatic compare_stream(input string name);
        n_checks++;
        if (obs.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s length: got %0d bytes, expected %0d", name, obs.size(), exp_q.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s byte %0d: got last=%b data=%h, expected last=%b data=%h",
                         name, i, obs[i][8], obs[i][7:0], exp_q[i][8], exp_q[i][7:0]);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        @(negedge clk);
        n_checks += 4;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
        if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset out_data: got %h expected 00", out_data); end
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset out_last: got %b expected 0", out_last); end
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_basic();
        pats_t p;
        p = {7'h3F, 7'h4F, 7'h7F, 7'h7F};
        ready_cmd = 1'b1;
        scan(p, 1'b0);
        scan(p, 1'b0);
        drive_idle();             // final strobe sampled at this edge (k)
        @(posedge clk); #1;       // k+1: commit only
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL latency k+1 out_valid: got %b expected 0", out_valid); end
        @(posedge clk); #1;       // k+2: first byte presented
        n_checks += 2;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL latency k+2 out_valid: got %b expected 1", out_valid); end
        if (out_data !== 8'h30) begin n_fail++; $display("FAIL latency k+2 out_data: got %h expected 30", out_data); end
        drain("basic");
        compare_stream("basic");
    endtask

    task automatic test_no_repeat();
        pats_t p;
        p = {7'h3F, 7'h4F, 7'h7F, 7'h7F};
        repeat (5) scan(p, 1'b0);
        drive_idle();
        drain("no_repeat");
        compare_stream("no_repeat");
        p[0] = 7'h06;
        scan(p, 1'b0);
        scan(p, 1'b0);
        drive_idle();
        drain("change");
        compare_stream("change");
    endtask

    task automatic test_decode_edge();
        pats_t      p;
        logic [8:0] e1[5];
        e1 = '{9'h03F, 9'h020, 9'h02D, 9'h045, 9'h10A};
        p  = {7'h7E, 7'h00, 7'h40, 7'h79};
        obs1.delete();
        scan(p, 1'b0);
        drive_idle();
        drain("decode1");
        n_checks++;
        if (obs1.size() !== 5) begin n_fail++; $display("FAIL decode single-scan length: got %0d expected 5", obs1.size()); end
        for (int i = 0; i < 5 && i < obs1.size(); i++) begin
            n_checks++;
            if (obs1[i] !== e1[i]) begin
                n_fail++;
                $display("FAIL decode single-scan byte %0d: got %h expected %h", i, obs1[i], e1[i]);
            end
        end
        scan(p, 1'b0);
        drive_idle();
        drain("decode");
        compare_stream("decode");
    endtask

    task automatic test_backpressure();
        pats_t      f1, f2, f3;
        logic [7:0] d0;
        logic       l0;
        int         ovr0, cut;
        f1 = {7'h06, 7'h5B, 7'h4F, 7'h66};
        f2 = {7'h77, 7'h7C, 7'h39, 7'h5E};
        f3 = {7'h79, 7'h71, 7'h40, 7'h00};
        ready_cmd = 1'b0;
        scan(f1, 1'b0);
        scan(f1, 1'b0);
        drive_idle();
        repeat (3) @(posedge clk);
        set_ready(1'b1);
        set_ready(1'b0);
        @(posedge clk);
        @(negedge clk);
        d0 = out_data;
        l0 = out_last;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks += 3;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold valid cycle %0d: got %b expected 1", c, out_valid); end
            if (out_data !== d0) begin n_fail++; $display("FAIL hold data cycle %0d: got %h expected %h", c, out_data, d0); end
            if (out_last !== l0) begin n_fail++; $display("FAIL hold last cycle %0d: got %b expected %b", c, out_last, l0); end
        end
        ovr0 = ovr_cnt;
        cut  = exp_q.size();
        scan(f2, 1'b0);
        scan(f2, 1'b0);
        scan(f3, 1'b0);
        scan(f3, 1'b0);
        drive_idle();
        repeat (4) @(posedge clk);
        n_checks++;
        if (ovr_cnt - ovr0 !== 1) begin n_fail++; $display("FAIL overrun pulses: got %0d expected 1", ovr_cnt - ovr0); end
        // f2 was overwritten in the pending slot and is never sent
        for (int i = 0; i < N + 1; i++) exp_q.delete(cut);
        ready_cmd = 1'b1;
        drain("backpressure");
        compare_stream("backpressure");
    endtask

    task automatic test_non_onehot();
        pats_t  p;
        frame_t f;
        p = {7'h6D, 7'h7D, 7'h07, 7'h6F};
        for (int d = 0; d < N; d++) f[d] = ref_decode(p[d]);
        repeat (2) begin
            strobe(2, 7'h00);     // rewritten below before completion
            strobe(3, p[3]);
            strobe(2, p[2]);
            strobe(1, p[1]);
            @(posedge clk); #1;
            sample_stb = 1'b1; dig_en = 4'b0011; seg = 7'h00;
            @(posedge clk); #1;
            sample_stb = 1'b1; dig_en = 4'b0000; seg = 7'h00;
            strobe(0, p[0]);
            model_commit(f);
        end
        drive_idle();
        drain("non_onehot");
        compare_stream("non_onehot");
    endtask

    task automatic test_random();
        pats_t p;
        int    ovr0;
        logic [6:0] pool[18];
        pool = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71, 7'h40, 7'h00};
        ovr0 = ovr_cnt;
        rand_ready = 1'b1;
        p = '0;
        for (int g = 0; g < 30; g++) begin
            if (g == 0 || $urandom_range(0, 9) < 6) begin
                for (int d = 0; d < N; d++)
                    p[d] = ($urandom_range(0, 4) == 0) ? 7'($urandom) : pool[$urandom_range(0, 17)];
            end
            repeat ($urandom_range(1, 3)) begin
                scan(p, 1'b1);
                repeat ($urandom_range(0, 2)) drive_idle();
            end
            drive_idle();
            drain("random");
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        compare_stream("random");
        n_checks++;
        if (ovr_cnt !== ovr0) begin n_fail++; $display("FAIL random overrun: got %0d pulses expected 0", ovr_cnt - ovr0); end
    endtask

    task automatic test_async_reset();
        pats_t p;
        p = {7'h66, 7'h3F, 7'h3F, 7'h6D};
        ready_cmd = 1'b0;
        scan(p, 1'b0);
        scan(p, 1'b0);
        drive_idle();
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre-reset out_valid: got %b expected 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL async reset out_valid: got %b expected 0", out_valid); end
        if (out_last !== 1'b0) begin n_fail++; $display("FAIL async reset out_last: got %b expected 0", out_last); end
        if (out_data !== 8'h00) begin n_fail++; $display("FAIL async reset out_data: got %h expected 00", out_data); end
        model_reset();
        ready_cmd = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (obs.size() !== 0) begin n_fail++; $display("FAIL post-reset stray bytes: got %0d expected 0", obs.size()); end
        scan(p, 1'b0);
        scan(p, 1'b0);
        drive_idle();
        drain("after_reset");
        compare_stream("after_reset");
    endtask

    initial begin
        rst_n      = 1'b0;
        sample_stb = 1'b0;
        dig_en     = '0;
        seg        = '0;
        ready_cmd  = 1'b0;
        rand_ready = 1'b0;
        have_last  = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        test_basic();
        test_no_repeat();
        test_decode_edge();
        test_backpressure();
        test_non_onehot();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
